// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours:
// stall-vector bit positions, fetch FSM states, boot PC and IF->ID bus width.
package if_stage_pkg;

  localparam int STALL_W  = 6;
  localparam int STALL_IF = 0;
  localparam int STALL_ID = 1;
  localparam int STALL_EX = 2;
  localparam int STALL_MA = 3;
  localparam int STALL_WB = 4;
  localparam int STALL_CT = 5;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  // pc_valid plus the 64-bit pc
  localparam int IF_ID_BUS_W = 65;

  typedef enum logic {
    S_BOOT,
    S_RUN
  } if_state_e;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic logic [63:0] align4(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's pipeline-control inputs, IF->ID outputs and
// instruction SRAM port. master = fetch stage side, slave = environment side.
interface if_stage_if
  import if_stage_pkg::*;
#(
  parameter int PC_W = 64
);

  logic [STALL_W-1:0] stall;
  logic               br_e;
  logic [PC_W-1:0]    br_addr;

  logic               pc_valid;
  logic [PC_W-1:0]    pc;

  logic               inst_sram_en;
  logic [7:0]         inst_sram_we;
  logic [PC_W-1:0]    inst_sram_addr;
  logic [PC_W-1:0]    inst_sram_wdata;

  modport master (
    input  stall, br_e, br_addr,
    output pc_valid, pc,
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

  modport slave (
    output stall, br_e, br_addr,
    input  pc_valid, pc,
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
  );

endinterface

// File: rtl/if_stage_pc_redirect_buf.sv
// Holds a redirect that arrives while the PC is frozen and chooses the next
// PC: hold, live redirect, parked redirect, or sequential, in that order.
// Written so later exception/CSR redirect sources can reuse it.
module pc_redirect_buf #(
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            hold,
  input  logic            br_e,
  input  logic [PC_W-1:0] br_addr,
  input  logic [PC_W-1:0] cur_pc,
  output logic [PC_W-1:0] next_pc,
  output logic            pend_v
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  logic [PC_W-1:0] pend_addr;
  logic [PC_W-1:0] br_tgt;
  logic            unused_br_lo;

  assign br_tgt       = {br_addr[PC_W-1:2], 2'b00};
  assign unused_br_lo = ^br_addr[1:0];

  // Park redirects seen during a hold (youngest overwrites) and drop the
  // parked one as soon as the PC is allowed to move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
    end else if (en) begin
      if (hold) begin
        if (br_e) begin
          pend_v    <= 1'b1;
          pend_addr <= br_tgt;
        end
      end else begin
        pend_v <= 1'b0;
      end
    end
  end

  // Next-PC priority: a live redirect beats a parked one; wrap is silent.
  always_comb begin
    next_pc = cur_pc + PC_STEP;
    if (hold) begin
      next_pc = cur_pc;
    end else if (br_e) begin
      next_pc = br_tgt;
    end else if (pend_v) begin
      next_pc = pend_addr;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, presents pc/pc_valid to decode
// and drives the read-only 64-bit instruction SRAM port.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  if_stage_if.master bus
);

  if_state_e       state;
  logic [PC_W-1:0] pc_q;
  logic            pc_valid_q;
  logic            sram_en_q;
  logic [PC_W-1:0] next_pc;
  logic            run;
  logic            unused_pend_v;
  logic            unused_stall;

  assign run          = (state == S_RUN);
  assign unused_stall = ^bus.stall[STALL_W-1:1];

  pc_redirect_buf #(
    .PC_W (PC_W)
  ) u_redirect (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (run),
    .hold    (bus.stall[STALL_IF]),
    .br_e    (bus.br_e),
    .br_addr (bus.br_addr),
    .cur_pc  (pc_q),
    .next_pc (next_pc),
    .pend_v  (unused_pend_v)
  );

  // Boot spends one idle cycle with RESET_PC already loaded, then runs with
  // fetch enabled forever; the PC only advances in S_RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      sram_en_q  <= 1'b0;
    end else begin
      case (state)
        S_BOOT: begin
          state      <= S_RUN;
          pc_valid_q <= 1'b1;
          sram_en_q  <= 1'b1;
        end
        S_RUN: begin
          pc_q <= next_pc;
        end
      endcase
    end
  end

  assign bus.pc              = pc_q;
  assign bus.pc_valid        = pc_valid_q;
  assign bus.inst_sram_en    = sram_en_q;
  assign bus.inst_sram_we    = 8'h00;
  assign bus.inst_sram_addr  = {pc_q[PC_W-1:3], 3'b000};
  assign bus.inst_sram_wdata = '0;

  // Every fetch PC, including the boot PC, must be word aligned.
  ap_pc_aligned: assert property (@(posedge clk) pc_q[1:0] == 2'b00)
    else $error("fetch pc not word aligned");

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot sequence, redirect, stall hold,
// redirect-during-stall, wrap-around and asynchronous reset.
module tb_if_stage;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  if_stage_if #(.PC_W(64)) bus ();

  if_stage #(
    .PC_W     (64),
    .RESET_PC (RST_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] stall, input logic br_e,
                               input logic [63:0] br_addr);
    bus.stall   = stall;
    bus.br_e    = br_e;
    bus.br_addr = br_addr;
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkPc(input string tag, input logic [63:0] exp_pc);
    checkOutput({tag, ".pc"}, bus.pc, exp_pc);
    checkOutput({tag, ".valid"}, {63'd0, bus.pc_valid}, 64'd1);
    checkOutput({tag, ".en"}, {63'd0, bus.inst_sram_en}, 64'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(6'b0, 1'b0, 64'h0);

    step();
    step();
    checkOutput("rst.pc", bus.pc, RST_PC);
    checkOutput("rst.valid", {63'd0, bus.pc_valid}, 64'd0);
    checkOutput("rst.en", {63'd0, bus.inst_sram_en}, 64'd0);
    checkOutput("rst.addr", bus.inst_sram_addr, 64'h8000_0000);

    // Release reset: one boot cycle with nothing valid
    rst_n = 1'b1;
    #1;
    checkOutput("boot.valid", {63'd0, bus.pc_valid}, 64'd0);
    checkOutput("boot.en", {63'd0, bus.inst_sram_en}, 64'd0);

    step();
    checkPc("run0", 64'h8000_0000);
    checkOutput("run0.addr", bus.inst_sram_addr, 64'h8000_0000);
    checkOutput("run0.we", {56'd0, bus.inst_sram_we}, 64'd0);
    checkOutput("run0.wdata", bus.inst_sram_wdata, 64'd0);
    step();
    checkPc("run1", 64'h8000_0004);
    checkOutput("run1.addr", bus.inst_sram_addr, 64'h8000_0000);
    step();
    checkPc("run2", 64'h8000_0008);
    checkOutput("run2.addr", bus.inst_sram_addr, 64'h8000_0008);
    step();
    step();
    checkPc("run4", 64'h8000_0010);

    // Redirect with misaligned low bits
    applyStimulus(6'b0, 1'b1, 64'h8000_1236);
    step();
    applyStimulus(6'b0, 1'b0, 64'h0);
    checkPc("br.tgt", 64'h8000_1234);
    step();
    checkPc("br.seq", 64'h8000_1238);

    // Steer to 0x80000020 then stall for three cycles
    applyStimulus(6'b0, 1'b1, 64'h8000_0020);
    step();
    checkPc("st.start", 64'h8000_0020);
    applyStimulus(6'b000001, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkPc($sformatf("st.hold%0d", i), 64'h8000_0020);
    end
    applyStimulus(6'b0, 1'b0, 64'h0);
    step();
    checkPc("st.resume", 64'h8000_0024);

    // Two redirects during one stall: youngest wins
    applyStimulus(6'b000001, 1'b0, 64'h0);
    step();
    checkPc("pd.hold0", 64'h8000_0024);
    applyStimulus(6'b000001, 1'b1, 64'h8000_2000);
    step();
    applyStimulus(6'b000001, 1'b0, 64'h0);
    checkPc("pd.hold1", 64'h8000_0024);
    checkOutput("pd.pendv1", {63'd0, dut.u_redirect.pend_v}, 64'd1);
    step();
    applyStimulus(6'b000001, 1'b1, 64'h8000_3000);
    step();
    applyStimulus(6'b0, 1'b0, 64'h0);
    checkPc("pd.hold3", 64'h8000_0024);
    step();
    checkPc("pd.release", 64'h8000_3000);
    checkOutput("pd.pendv0", {63'd0, dut.u_redirect.pend_v}, 64'd0);
    step();
    checkPc("pd.seq", 64'h8000_3004);

    // Parked redirect loses to a live redirect on the release edge
    applyStimulus(6'b000001, 1'b1, 64'h8000_2000);
    step();
    checkPc("lv.hold", 64'h8000_3004);
    applyStimulus(6'b0, 1'b1, 64'h8000_4000);
    step();
    applyStimulus(6'b0, 1'b0, 64'h0);
    checkPc("lv.tgt", 64'h8000_4000);
    step();
    checkPc("lv.seq", 64'h8000_4004);

    // Wrap at the top of the address space
    applyStimulus(6'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    applyStimulus(6'b0, 1'b0, 64'h0);
    checkPc("wr.top", 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wr.addr", bus.inst_sram_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    step();
    checkPc("wr.zero", 64'h0);
    step();
    checkPc("wr.four", 64'h4);

    // Asynchronous reset in the middle of a stall with a parked redirect
    applyStimulus(6'b000001, 1'b1, 64'h8000_5000);
    step();
    applyStimulus(6'b000001, 1'b0, 64'h0);
    checkOutput("ar.pendv1", {63'd0, dut.u_redirect.pend_v}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar.pc", bus.pc, RST_PC);
    checkOutput("ar.valid", {63'd0, bus.pc_valid}, 64'd0);
    checkOutput("ar.en", {63'd0, bus.inst_sram_en}, 64'd0);
    checkOutput("ar.pendv0", {63'd0, dut.u_redirect.pend_v}, 64'd0);
    step();
    rst_n = 1'b1;
    // stall[0] still high: boot must not be delayed by it
    step();
    checkPc("ar.boot", RST_PC);
    step();
    checkPc("ar.hold", RST_PC);
    applyStimulus(6'b0, 1'b0, 64'h0);
    step();
    checkPc("ar.seq", RST_PC + 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
